aes_inv_round_iter: RTL and testbench

Iterative AES-128 inverse cipher datapath. It decrypts one 128-bit block in 20 cycles, spending two clock cycles on each inverse round. Round keys are supplied by an external key store that the block indexes one round at a time. It is the decrypt-side counterpart to the two-cycle-per-round encryption rounds and sits between the key-schedule storage and the bus wrapper.

---
 rtl/aes_inv_round_iter.sv | 181 ++++++++++++++++++
 tb/tb_aes_inv_round_iter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 inverse cipher: one inverse round every two cycles (SUB then MIX),
// with round keys fetched from an external key store indexed by key_idx.
module aes_inv_round_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] pt
);

  typedef enum logic [1:0] {IDLE, SUB, MIX} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] tmp_q, tmp_d;
  logic [127:0] pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] round_in;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and naturally maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] aff;
    aff = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    return gf_inv(aff);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign round_in = tmp_q ^ key_in;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    tmp_d   = tmp_q;
    pt_d    = pt_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = ct ^ key_in;
          rnd_d   = 4'd9;
          busy_d  = 1'b1;
          fsm_d   = SUB;
        end
      end
      SUB: begin
        tmp_d = inv_sub_bytes(inv_shift_rows(state_q));
        fsm_d = MIX;
      end
      MIX: begin
        if (rnd_q != 4'd0) begin
          state_d = inv_mix_columns(round_in);
          rnd_d   = rnd_q - 4'd1;
          fsm_d   = SUB;
        end else begin
          pt_d   = round_in;
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      tmp_q   <= '0;
      pt_q    <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      tmp_q   <= tmp_d;
      pt_q    <= pt_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key_idx = (fsm_q == IDLE) ? 4'd10 : rnd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pt      = pt_q;

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Self-checking bench for aes_inv_round_iter: a forward AES-128 model encrypts
// known and random plaintexts, and the DUT must recover them in exactly 20 cycles.
module tb_aes_inv_round_iter;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] ct;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic [127:0] pt;

  logic [127:0] rk [11];
  logic [7:0]   sbox [256];
  int           n_cmp = 0;
  int           n_err = 0;

  aes_inv_round_iter dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ct      (ct),
    .key_idx (key_idx),
    .key_in  (key_in),
    .busy    (busy),
    .done    (done),
    .pt      (pt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The key store answers combinationally for whatever index the DUT requests
  always_comb begin
    key_in = '0;
    if (key_idx <= 4'd10) key_in = rk[key_idx];
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int prod;
    prod = 0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (32'h11b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a falling edge while the DUT is idle (or in its done cycle)
  task automatic applyStimulus(input logic [127:0] ct_v);
    checkOutput("key_idx_accept", key_idx, 128'd10);
    start = 1'b1;
    ct    = ct_v;
    @(negedge clk);
    start = 1'b0;
    ct    = rand128();
    checkOutput("done_pulse_width", done, 128'd0);
  endtask

  // Entered at the falling edge after acceptance; returns at the done cycle
  task automatic waitDone(input logic [127:0] exp_pt, input bit chk_keys, input bit poke_start,
                          input bit chk_hold, input logic [127:0] hold_val);
    int k;
    int busy_cnt;
    k = 0;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      if (chk_keys && k < 20) checkOutput("key_idx_seq", key_idx, 128'(9 - k / 2));
      if (chk_hold) checkOutput("pt_hold", pt, hold_val);
      start = poke_start && (k == 3 || k == 7 || k == 15);
      ct    = rand128();
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checkOutput("latency", 128'(k), 128'd20);
    checkOutput("busy_cycles", 128'(busy_cnt), 128'd20);
    checkOutput("busy_at_done", busy, 128'd0);
    checkOutput("pt", pt, exp_pt);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] key_r, pt_r;
    int dones;
    rst   = 1'b1;
    start = 1'b0;
    ct    = '0;
    buildSbox();
    expandKey(C1_KEY);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 128'd0);
    checkOutput("reset_done", done, 128'd0);
    checkOutput("reset_pt", pt, 128'd0);
    checkOutput("reset_key_idx", key_idx, 128'd10);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(C1_CT);
    waitDone(C1_PT, 1'b1, 1'b0, 1'b0, '0);

    $display("[TB] zero key vector");
    expandKey('0);
    applyStimulus(Z_CT);
    waitDone('0, 1'b1, 1'b0, 1'b0, '0);

    $display("[TB] back-to-back blocks");
    expandKey(C1_KEY);
    applyStimulus(C1_CT);
    waitDone(C1_PT, 1'b0, 1'b0, 1'b0, '0);
    expandKey('0);
    applyStimulus(Z_CT);
    waitDone('0, 1'b0, 1'b0, 1'b1, C1_PT);

    $display("[TB] start pulses while busy");
    expandKey(C1_KEY);
    applyStimulus(C1_CT);
    waitDone(C1_PT, 1'b0, 1'b1, 1'b0, '0);

    $display("[TB] reset mid-block");
    applyStimulus(C1_CT);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 128'd0);
    checkOutput("midrst_done", done, 128'd0);
    checkOutput("midrst_pt", pt, 128'd0);
    checkOutput("midrst_key_idx", key_idx, 128'd10);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("midrst_no_done", 128'(dones), 128'd0);
    applyStimulus(C1_CT);
    waitDone(C1_PT, 1'b0, 1'b0, 1'b0, '0);

    $display("[TB] randomized blocks");
    for (int n = 0; n < 1000; n++) begin
      key_r = rand128();
      pt_r  = rand128();
      expandKey(key_r);
      applyStimulus(encrypt(pt_r));
      waitDone(pt_r, 1'b0, 1'b0, 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
